// File: rtl/fifo_rd_stream_pkg.sv
// fifo_rd_stream shared defaults and helpers.
// Optional framing is enabled with FIFO_RD_STREAM_LAST_EN.
package fifo_rd_stream_pkg;

  localparam int DSIZE_DEF      = 16;
  localparam int SKID_DEPTH_DEF = 2;
  localparam int PKT_LEN_DEF    = 8;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Circular skid buffer absorbing the FIFO read latency.
// Head entry is always presented on data_o.
module fifo_rd_skid
  import fifo_rd_stream_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int DEPTH = SKID_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [DSIZE-1:0]           data_i,
  input  logic                       pop_i,
  output logic [DSIZE-1:0]           data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DSIZE-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // DEPTH is a power of two, so the pointers wrap naturally
  always_comb begin
    wptr_d = wptr_q + PW'(push_i);
    rptr_d = rptr_q + PW'(pop_i);
    cnt_d  = cnt_q + CW'(push_i) - CW'(pop_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= data_i;
  end

  assign data_o  = mem_q[rptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side drain engine: credit-based pops into a skid buffer.
// Define FIFO_RD_STREAM_LAST_EN to frame words into PKT_LEN packets.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DSIZE      = DSIZE_DEF,
  parameter int SKID_DEPTH = SKID_DEPTH_DEF,
  parameter int PKT_LEN    = PKT_LEN_DEF
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             rempty,
  output logic             rinc,
  input  logic [DSIZE-1:0] fifo_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSIZE-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int CW = $clog2(SKID_DEPTH+1);

  logic [CW-1:0] count;
  logic [CW:0]   used;
  logic          inflight_q, inflight_d;
  logic          accept;

  assign accept = out_valid & out_ready;

  // Credit counts the pop in flight and frees the slot accepted now
  always_comb begin
    used = {1'b0, count} + (CW+1)'(inflight_q)
         - (CW+1)'(accept);
    rinc = !rrst & !rempty
         & (used < (CW+1)'(SKID_DEPTH));
    inflight_d = rinc;
  end

  always_ff @(posedge rclk) begin
    if (rrst) inflight_q <= 1'b0;
    else      inflight_q <= inflight_d;
  end

  fifo_rd_skid #(
    .DSIZE (DSIZE),
    .DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk     (rclk),
    .rst     (rrst),
    .push_i  (inflight_q),
    .data_i  (fifo_rdata),
    .pop_i   (accept),
    .data_o  (out_data),
    .count_o (count)
  );

  assign out_valid = (count != '0);
  assign busy      = out_valid | inflight_q;

`ifdef FIFO_RD_STREAM_LAST_EN
  localparam int LW = ptr_w(PKT_LEN);

  logic [LW-1:0] wcnt_q, wcnt_d;
  logic          wrap;

  assign wrap = (wcnt_q == LW'(PKT_LEN-1));

  always_comb begin
    wcnt_d = wcnt_q;
    if (accept) wcnt_d = wrap ? '0 : wcnt_q + 1'b1;
  end

  always_ff @(posedge rclk) begin
    if (rrst) wcnt_q <= '0;
    else      wcnt_q <= wcnt_d;
  end

  assign out_last = out_valid & wrap;
`else
  logic unused_pkt;
  assign unused_pkt = (PKT_LEN > 0);
  assign out_last   = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Randomized bench for fifo_rd_stream against a counting model.
// Build with FIFO_RD_STREAM_LAST_EN to also check packet framing.
module tb_fifo_rd_stream;

  localparam int DW = 16;
  localparam int D  = 2;
`ifdef FIFO_RD_STREAM_LAST_EN
  localparam int PL = 4;
`else
  localparam int PL = 8;
`endif

  logic          rclk = 1'b0;
  logic          rrst = 1'b1;
  logic          rempty = 1'b1;
  logic          rinc;
  logic [DW-1:0] fifo_rdata = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;

  always #5 rclk = ~rclk;

  fifo_rd_stream #(
    .DSIZE      (DW),
    .SKID_DEPTH (D),
    .PKT_LEN    (PL)
  ) dut (
    .rclk       (rclk),
    .rrst       (rrst),
    .rempty     (rempty),
    .rinc       (rinc),
    .fifo_rdata (fifo_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy)
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];

  // model: pops issued, pops captured, accepts (since reset)
  int pops, caps, accs;
  bit pop_prev;
  int dpops, daccs, rinc_cnt;
  bit st_prev;
  logic [DW-1:0] st_data;
  logic st_last;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    bit ev, er, eb, el, acc, r, a;
    er = 1'b0;
    acc = 1'b0;
    @(negedge rclk);
    r = rinc;
    a = out_valid & out_ready;
    if (rrst) begin
      chk("rinc_in_rst", rinc, 0);
    end else begin
      ev  = (caps - accs) > 0;
      acc = ev && out_ready;
      er  = !rempty && (pops - accs - int'(acc)) < D;
      eb  = (pops - accs) > 0;
`ifdef FIFO_RD_STREAM_LAST_EN
      el  = ev && ((accs % PL) == PL - 1);
`else
      el  = 1'b0;
`endif
      chk("valid", out_valid, ev);
      chk("rinc", rinc, er);
      chk("busy", busy, eb);
      chk("last", out_last, el);
      chk("credit", (dpops - daccs) <= D, 1);
      if (st_prev) begin
        chk("stall_data", out_data, st_data);
        chk("stall_last", out_last, st_last);
      end
      if (a) begin
        if (exp_q.size() == 0) chk("spurious", 1, 0);
        else chk("data", out_data, exp_q.pop_front());
      end
      st_prev = out_valid && !out_ready;
      st_data = out_data;
      st_last = out_last;
    end
    @(posedge rclk);
    #1;
    if (rrst) begin
      pops = 0; caps = 0; accs = 0;
      pop_prev = 0; st_prev = 0;
      dpops = 0; daccs = 0;
      fifo_q.delete();
      exp_q.delete();
      fifo_rdata = DW'($urandom);
    end else begin
      caps += int'(pop_prev);
      pop_prev = er;
      pops += int'(er);
      accs += int'(acc);
      dpops += int'(r);
      daccs += int'(a);
      if (r) begin
        rinc_cnt++;
        if (fifo_q.size() > 0) fifo_rdata = fifo_q.pop_front();
        else fifo_rdata = 16'hDEAD;
      end
    end
    rempty = (fifo_q.size() == 0);
  endtask

  task automatic push(logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    rempty = 1'b0;
  endtask

  task automatic do_reset();
    rrst = 1'b1;
    cycle();
    rrst = 1'b0;
  endtask

  task automatic drain(int lim, bit rnd);
    for (int i = 0; i < lim && (exp_q.size() > 0 || busy); i++) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cycle();
    end
    chk("drained", exp_q.size(), 0);
  endtask

  initial begin
    do_reset();
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_last", out_last, 0);
    chk("rst_rinc", rinc, 0);

    // four words at full throughput
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) push(DW'(i));
    rinc_cnt = 0;
    repeat (8) cycle();
    chk("t1_pops", rinc_cnt, 4);
    chk("t1_left", exp_q.size(), 0);
    chk("t1_busy", busy, 0);

    // backpressure holds pops at the buffer depth
    out_ready = 1'b0;
    for (int i = 1; i <= 10; i++) push(DW'(i));
    rinc_cnt = 0;
    repeat (6) cycle();
    chk("t2_pops", rinc_cnt, D);
    chk("t2_head", out_data, 1);
    out_ready = 1'b1;
    repeat (12) cycle();
    chk("t2_left", exp_q.size(), 0);
    chk("t2_pops_all", rinc_cnt, 10);

    // long random run
    for (int i = 0; i < 1000; i++) push(DW'($urandom));
    drain(6000, 1);

    // trickle words so rempty toggles
    for (int i = 0; i < 60; i++) begin
      push(DW'($urandom));
      for (int g = $urandom_range(0, 4); g >= 0; g--) begin
        out_ready = 1'($urandom_range(0, 1));
        cycle();
      end
    end
    drain(1000, 1);

    // reset while buffered and in flight
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(DW'(16'h0100 + i));
    repeat (3) cycle();
    out_ready = 1'b1;
    cycle();
    do_reset();
    chk("mrst_valid", out_valid, 0);
    chk("mrst_busy", busy, 0);
    for (int i = 1; i <= 4; i++) push(DW'(16'hA000 + i));
    drain(200, 0);
    repeat (3) cycle();

    // framing under random backpressure
    do_reset();
    for (int i = 1; i <= 12; i++) push(DW'(16'h0C00 + i));
    drain(500, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
